mips_bus_arbiter: RTL and testbench

// Shares the CPU's single Avalon-MM master port between the instruction-fetch requester (I, read-only)
// and the load/store requester (D). Accepts one request at a time, drives the Avalon master signals

---
 rtl/mips_bus_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_mips_bus_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_bus_arbiter.sv
// Two-requester arbiter sharing one Avalon-MM master port between instruction fetch (I) and load/store (D).
// One transfer at a time: IDLE grants, XFER holds the bus until waitrequest drops, RESP issues a one-cycle ack.
module mips_bus_arbiter #(
    parameter int RR_MODE = 1,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_byteen,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic        busy,
    output logic        grant_d,
    output logic        bus_error
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    state_t             state_r, state_nx_s;
    logic [31:0]        address_r, address_nx_s;
    logic [31:0]        writedata_r, writedata_nx_s;
    logic [3:0]         byteenable_r, byteenable_nx_s;
    logic               read_r, read_nx_s;
    logic               write_r, write_nx_s;
    logic               i_ack_r, i_ack_nx_s;
    logic               d_ack_r, d_ack_nx_s;
    logic [31:0]        i_rdata_r, i_rdata_nx_s;
    logic [31:0]        d_rdata_r, d_rdata_nx_s;
    logic               busy_r, busy_nx_s;
    logic               grant_d_r, grant_d_nx_s;
    logic               bus_error_r, bus_error_nx_s;
    logic [CNT_W-1:0]   wait_cnt_r, wait_cnt_nx_s;
    logic [CNT_W-1:0]   wait_inc_s;
    logic               pick_d_s;

    // Winner selection; on a tie round-robin favours whoever did not own the last transfer
    always_comb begin
        if (i_req && d_req) begin
            if (RR_MODE != 0) begin
                pick_d_s = ~grant_d_r;
            end else begin
                pick_d_s = 1'b1;
            end
        end else begin
            pick_d_s = d_req;
        end
    end

    // Saturating increment of the stall counter
    always_comb begin
        if (wait_cnt_r == CNT_MAX) begin
            wait_inc_s = CNT_MAX;
        end else begin
            wait_inc_s = wait_cnt_r + CNT_W'(1);
        end
    end

    // Next-state and next-output logic; acks default low so they pulse for exactly one cycle
    always_comb begin
        state_nx_s      = state_r;
        address_nx_s    = address_r;
        writedata_nx_s  = writedata_r;
        byteenable_nx_s = byteenable_r;
        read_nx_s       = read_r;
        write_nx_s      = write_r;
        i_ack_nx_s      = 1'b0;
        d_ack_nx_s      = 1'b0;
        i_rdata_nx_s    = i_rdata_r;
        d_rdata_nx_s    = d_rdata_r;
        grant_d_nx_s    = grant_d_r;
        bus_error_nx_s  = bus_error_r;
        wait_cnt_nx_s   = wait_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    state_nx_s   = ST_XFER;
                    grant_d_nx_s = pick_d_s;
                    if (pick_d_s) begin
                        address_nx_s    = d_addr;
                        writedata_nx_s  = d_wdata;
                        byteenable_nx_s = d_byteen;
                        read_nx_s       = ~d_write;
                        write_nx_s      = d_write;
                    end else begin
                        address_nx_s    = i_addr;
                        writedata_nx_s  = 32'h0000_0000;
                        byteenable_nx_s = 4'b1111;
                        read_nx_s       = 1'b1;
                        write_nx_s      = 1'b0;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (!waitrequest) begin
                    state_nx_s    = ST_RESP;
                    read_nx_s     = 1'b0;
                    write_nx_s    = 1'b0;
                    wait_cnt_nx_s = {CNT_W{1'b0}};
                    if (grant_d_r) begin
                        d_ack_nx_s = 1'b1;
                        if (read_r) begin
                            d_rdata_nx_s = readdata;
                        end else begin
                            d_rdata_nx_s = d_rdata_r;
                        end
                    end else begin
                        i_ack_nx_s   = 1'b1;
                        i_rdata_nx_s = readdata;
                    end
                end else begin
                    wait_cnt_nx_s = wait_inc_s;
                    // The timeout only flags the stall; the transfer keeps waiting
                    if ((TIMEOUT != 0) && (wait_inc_s >= TIMEOUT_C)) begin
                        bus_error_nx_s = 1'b1;
                    end else begin
                        bus_error_nx_s = bus_error_r;
                    end
                end
            end
            ST_RESP: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
                read_nx_s  = 1'b0;
                write_nx_s = 1'b0;
            end
        endcase
        busy_nx_s = (state_nx_s != ST_IDLE);
    end

    // State and output registers; reset abandons any transfer in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            address_r    <= 32'h0000_0000;
            writedata_r  <= 32'h0000_0000;
            byteenable_r <= 4'b0000;
            read_r       <= 1'b0;
            write_r      <= 1'b0;
            i_ack_r      <= 1'b0;
            d_ack_r      <= 1'b0;
            i_rdata_r    <= 32'h0000_0000;
            d_rdata_r    <= 32'h0000_0000;
            busy_r       <= 1'b0;
            grant_d_r    <= 1'b1;
            bus_error_r  <= 1'b0;
            wait_cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r      <= state_nx_s;
            address_r    <= address_nx_s;
            writedata_r  <= writedata_nx_s;
            byteenable_r <= byteenable_nx_s;
            read_r       <= read_nx_s;
            write_r      <= write_nx_s;
            i_ack_r      <= i_ack_nx_s;
            d_ack_r      <= d_ack_nx_s;
            i_rdata_r    <= i_rdata_nx_s;
            d_rdata_r    <= d_rdata_nx_s;
            busy_r       <= busy_nx_s;
            grant_d_r    <= grant_d_nx_s;
            bus_error_r  <= bus_error_nx_s;
            wait_cnt_r   <= wait_cnt_nx_s;
        end
    end

    assign address    = address_r;
    assign writedata  = writedata_r;
    assign byteenable = byteenable_r;
    assign read       = read_r;
    assign write      = write_r;
    assign i_ack      = i_ack_r;
    assign d_ack      = d_ack_r;
    assign i_rdata    = i_rdata_r;
    assign d_rdata    = d_rdata_r;
    assign busy       = busy_r;
    assign grant_d    = grant_d_r;
    assign bus_error  = bus_error_r;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Bench for mips_bus_arbiter: transaction-level reference model, vector table, directed corner sequences, random traffic.
module tb_mips_bus_arbiter;

    localparam int RR = 1;
    localparam int TO = 4;
    localparam int CW = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_write, waitrequest;
    logic [31:0] i_addr, d_addr, d_wdata, readdata;
    logic [3:0]  d_byteen;

    logic        i_ack, d_ack, read, write, busy, grant_d, bus_error;
    logic [31:0] i_rdata, d_rdata, address, writedata;
    logic [3:0]  byteenable;

    logic        fp_i_ack, fp_d_ack, fp_read, fp_write, fp_busy, fp_grant_d, fp_bus_error;
    logic [31:0] fp_i_rdata, fp_d_rdata, fp_address, fp_writedata;
    logic [3:0]  fp_byteenable;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mips_bus_arbiter #(.RR_MODE(RR), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata), .d_byteen(d_byteen),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .address(address), .read(read), .write(write), .writedata(writedata), .byteenable(byteenable),
        .waitrequest(waitrequest), .readdata(readdata),
        .busy(busy), .grant_d(grant_d), .bus_error(bus_error)
    );

    mips_bus_arbiter #(.RR_MODE(0), .TIMEOUT(0), .CNT_W(CW)) dut_fp (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(fp_i_ack), .i_rdata(fp_i_rdata),
        .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata), .d_byteen(d_byteen),
        .d_ack(fp_d_ack), .d_rdata(fp_d_rdata),
        .address(fp_address), .read(fp_read), .write(fp_write), .writedata(fp_writedata),
        .byteenable(fp_byteenable),
        .waitrequest(waitrequest), .readdata(readdata),
        .busy(fp_busy), .grant_d(fp_grant_d), .bus_error(fp_bus_error)
    );

    // Reference model: one outstanding transaction record plus response flag
    bit          m_active, m_resp, m_is_d, m_wr, m_last_d, m_err, m_iack, m_dack;
    logic [31:0] m_addr, m_wdata, m_irdata, m_drdata;
    logic [3:0]  m_be;
    int          m_wait;

    task automatic model_reset();
        m_active = 0; m_resp = 0; m_is_d = 0; m_wr = 0; m_last_d = 1; m_err = 0;
        m_iack = 0; m_dack = 0; m_addr = 0; m_wdata = 0; m_irdata = 0; m_drdata = 0;
        m_be = 0; m_wait = 0;
    endtask

    task automatic model_step();
        bit pick_d;
        m_iack = 0;
        m_dack = 0;
        if (!reset) begin
            model_reset();
        end else if (m_resp) begin
            m_resp = 0;
        end else if (m_active) begin
            if (!waitrequest) begin
                m_active = 0;
                m_resp   = 1;
                m_wait   = 0;
                if (m_is_d) begin
                    m_dack = 1;
                    if (!m_wr) m_drdata = readdata;
                end else begin
                    m_iack   = 1;
                    m_irdata = readdata;
                end
            end else begin
                if (m_wait < (1 << CW) - 1) m_wait++;
                if (TO != 0 && m_wait >= TO) m_err = 1;
            end
        end else if (i_req || d_req) begin
            if (i_req && d_req) pick_d = (RR != 0) ? !m_last_d : 1'b1;
            else pick_d = d_req;
            m_active = 1;
            m_is_d   = pick_d;
            m_last_d = pick_d;
            if (pick_d) begin
                m_wr = d_write; m_addr = d_addr; m_wdata = d_wdata; m_be = d_byteen;
            end else begin
                m_wr = 0; m_addr = i_addr; m_wdata = 0; m_be = 4'hF;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check("read",       {31'd0, read},       {31'd0, m_active && !m_wr});
        check("write",      {31'd0, write},      {31'd0, m_active && m_wr});
        check("address",    address,             m_addr);
        check("writedata",  writedata,           m_wdata);
        check("byteenable", {28'd0, byteenable}, {28'd0, m_be});
        check("i_ack",      {31'd0, i_ack},      {31'd0, m_iack});
        check("d_ack",      {31'd0, d_ack},      {31'd0, m_dack});
        check("i_rdata",    i_rdata,             m_irdata);
        check("d_rdata",    d_rdata,             m_drdata);
        check("busy",       {31'd0, busy},       {31'd0, m_active || m_resp});
        check("grant_d",    {31'd0, grant_d},    {31'd0, m_last_d});
        check("bus_error",  {31'd0, bus_error},  {31'd0, m_err});
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic idle_inputs();
        i_req = 0; d_req = 0; d_write = 0; waitrequest = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0; d_byteen = 0; readdata = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 0;
        model_reset();
        step();
        step();
        reset = 1;
    endtask

    typedef struct {
        bit          is_d;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        int          nwait;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_irdata;
        logic [31:0] exp_drdata;
    } vec_t;

    vec_t vecs[5];
    vec_t v;

    initial begin
        vecs[0] = '{0, 0, 32'hBFC0_0000, 32'h0,         4'h0, 32'h2402_0005, 0, 4'hF, 32'h0,         32'h2402_0005, 32'h0};
        vecs[1] = '{1, 1, 32'h0000_1000, 32'hDEAD_BEEF, 4'h3, 32'h1234_5678, 3, 4'h3, 32'hDEAD_BEEF, 32'h2402_0005, 32'h0};
        vecs[2] = '{1, 0, 32'h0000_2004, 32'h1111_1111, 4'hF, 32'hCAFE_F00D, 1, 4'hF, 32'h1111_1111, 32'h2402_0005, 32'hCAFE_F00D};
        vecs[3] = '{1, 1, 32'h0000_3000, 32'h55AA_55AA, 4'hC, 32'h9999_9999, 0, 4'hC, 32'h55AA_55AA, 32'h2402_0005, 32'hCAFE_F00D};
        vecs[4] = '{0, 0, 32'hBFC0_0004, 32'h0,         4'h0, 32'h8C43_0000, 2, 4'hF, 32'h0,         32'h8C43_0000, 32'hCAFE_F00D};

        // Reset held with a pending fetch: everything zero except grant_d
        idle_inputs();
        reset = 0;
        model_reset();
        i_req = 1; i_addr = 32'h0000_0100; readdata = 32'hA5A5_A5A5;
        for (int k = 0; k < 2; k++) begin
            step();
            check("rst_read", {31'd0, read}, 32'd0);
            check("rst_busy", {31'd0, busy}, 32'd0);
            check("rst_grant_d", {31'd0, grant_d}, 32'd1);
            check("rst_address", address, 32'd0);
        end
        reset = 1;
        step();
        check("rel_read", {31'd0, read}, 32'd1);
        check("rel_address", address, 32'h0000_0100);
        step();
        check("rel_i_ack", {31'd0, i_ack}, 32'd1);
        check("rel_i_rdata", i_rdata, 32'hA5A5_A5A5);
        i_req = 0;
        step();

        // Single-transfer vector table
        for (int k = 0; k < 5; k++) begin
            v = vecs[k];
            i_req = !v.is_d; d_req = v.is_d;
            i_addr = v.addr; d_addr = v.addr; d_write = v.wr; d_wdata = v.wdata; d_byteen = v.be;
            readdata = v.rdata; waitrequest = (v.nwait > 0);
            step();
            for (int w = 0; w <= v.nwait; w++) begin
                if (w > 0) step();
                check("tbl_read", {31'd0, read}, {31'd0, !v.wr});
                check("tbl_write", {31'd0, write}, {31'd0, v.wr});
                check("tbl_address", address, v.addr);
                check("tbl_byteenable", {28'd0, byteenable}, {28'd0, v.exp_be});
                check("tbl_writedata", writedata, v.exp_wdata);
                check("tbl_grant_d", {31'd0, grant_d}, {31'd0, v.is_d});
                check("tbl_no_ack", {31'd0, i_ack | d_ack}, 32'd0);
            end
            waitrequest = 0;
            step();
            check("tbl_i_ack", {31'd0, i_ack}, {31'd0, !v.is_d});
            check("tbl_d_ack", {31'd0, d_ack}, {31'd0, v.is_d});
            check("tbl_bus_idle", {30'd0, read, write}, 32'd0);
            check("tbl_i_rdata", i_rdata, v.exp_irdata);
            check("tbl_d_rdata", d_rdata, v.exp_drdata);
            i_req = 0; d_req = 0;
            step();
            check("tbl_ack_gone", {31'd0, i_ack | d_ack}, 32'd0);
            check("tbl_busy", {31'd0, busy}, 32'd0);
        end

        // Continuous contention: round-robin alternates I,D,I,D; fixed priority always D
        do_reset();
        i_req = 1; d_req = 1; i_addr = 32'h0000_4000; d_addr = 32'h0000_8000; d_write = 0;
        d_byteen = 4'hF; readdata = 32'h0F0F_0F0F;
        for (int t = 0; t < 4; t++) begin
            step();
            check("rr_grant_d", {31'd0, grant_d}, t % 2);
            check("rr_address", address, (t % 2) ? 32'h0000_8000 : 32'h0000_4000);
            check("fp_grant_d", {31'd0, fp_grant_d}, 32'd1);
            check("fp_address", fp_address, 32'h0000_8000);
            step();
            check("rr_i_ack", {31'd0, i_ack}, {31'd0, (t % 2) == 0});
            check("rr_d_ack", {31'd0, d_ack}, {31'd0, (t % 2) == 1});
            check("fp_d_ack", {31'd0, fp_d_ack}, 32'd1);
            check("fp_i_ack", {31'd0, fp_i_ack}, 32'd0);
            step();
        end
        i_req = 0; d_req = 0;
        step();

        // Stuck waitrequest: bus_error after 4 wait cycles, read held, ack only once released
        i_req = 1; i_addr = 32'h0000_0040; waitrequest = 1; readdata = 32'h7777_0000;
        step();
        for (int k = 1; k <= 6; k++) begin
            step();
            check("to_bus_error", {31'd0, bus_error}, {31'd0, k >= TO});
            check("to_read", {31'd0, read}, 32'd1);
        end
        waitrequest = 0;
        step();
        check("to_i_ack", {31'd0, i_ack}, 32'd1);
        i_req = 0;
        step();
        check("to_sticky", {31'd0, bus_error}, 32'd1);

        // Reset in the middle of a stalled load, then a fresh load is served
        d_req = 1; d_write = 0; d_addr = 32'h0000_0500; d_byteen = 4'hF; waitrequest = 1;
        step();
        step();
        check("mid_read_before", {31'd0, read}, 32'd1);
        #2;
        reset = 0;
        #1;
        model_reset();
        check("mid_read_async", {31'd0, read}, 32'd0);
        check("mid_busy_async", {31'd0, busy}, 32'd0);
        check("mid_err_cleared", {31'd0, bus_error}, 32'd0);
        step();
        check("mid_no_ack", {31'd0, d_ack | i_ack}, 32'd0);
        reset = 1; waitrequest = 0; readdata = 32'h0BAD_F00D;
        step();
        check("mid_new_read", {31'd0, read}, 32'd1);
        step();
        check("mid_new_d_ack", {31'd0, d_ack}, 32'd1);
        check("mid_new_d_rdata", d_rdata, 32'h0BAD_F00D);
        d_req = 0;
        step();

        // Random traffic against the model; requesters hold fields until their ack
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (!i_req && $urandom_range(0, 2) == 0) begin
                i_req = 1; i_addr = $urandom;
            end
            if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1; d_addr = $urandom; d_wdata = $urandom;
                d_write = 1'($urandom_range(0, 1)); d_byteen = 4'($urandom_range(0, 15));
            end
            waitrequest = ($urandom_range(0, 4) < 2);
            readdata = $urandom;
            step();
            if (m_iack) begin
                i_req = 1'($urandom_range(0, 1)); i_addr = $urandom;
            end
            if (m_dack) begin
                d_req = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom;
                d_write = 1'($urandom_range(0, 1)); d_byteen = 4'($urandom_range(0, 15));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
